// File: rtl/seg_status_display.sv
// Seven-segment status/time driver: recorder-state glyph, transient event glyph and decimal elapsed seconds.
// Build option: define SEG_LEADING_ZERO_BLANK_EN to blank leading zero time digits (units digit always shown).
module seg_status_display #(
  parameter int NUM_DIGITS = 8,
  parameter int TIME_W     = 20,
  parameter int CLK_HZ     = 50_000_000,
  parameter int BLINK_MS   = 500,
  parameter int FLASH_MS   = 300
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [TIME_W-1:0]       i_time,
  input  logic                    i_time_valid,
  input  logic [2:0]              i_stat,
  input  logic [15:0]             i_input_event,
  output logic [7*NUM_DIGITS-1:0] o_seg,
  output logic                    o_busy
);

  localparam int TD        = NUM_DIGITS - 2;
  localparam int MS_CYCLES = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int MS_W      = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
  localparam int BL_W      = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int HOLD_W    = $clog2(FLASH_MS + 1);
  localparam int BIT_W     = $clog2(TIME_W + 1);

  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_P     = 7'h0C;
  localparam logic [6:0] G_H     = 7'h09;
  localparam logic [6:0] G_S     = 7'h12;
  localparam logic [6:0] G_R     = 7'h2F;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_BLANK = 7'h7F;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]     SAT_LIMIT = pow10(TD);
  localparam logic [4*TD-1:0] ALL_NINES = {TD{4'h9}};

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0: g = 7'h40;
      4'd1: g = 7'h79;
      4'd2: g = 7'h24;
      4'd3: g = 7'h30;
      4'd4: g = 7'h19;
      4'd5: g = 7'h12;
      4'd6: g = 7'h02;
      4'd7: g = 7'h78;
      4'd8: g = 7'h00;
      4'd9: g = 7'h10;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  // ---------------- 1 ms prescaler and blink phase ----------------
  logic [MS_W-1:0] ms_cnt_reg;
  logic            tick;
  logic [BL_W-1:0] blink_cnt_reg;
  logic            blink_phase_reg;

  assign tick = (ms_cnt_reg == MS_W'(MS_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ms_cnt_reg <= '0;
    end else if (tick) begin
      ms_cnt_reg <= '0;
    end else begin
      ms_cnt_reg <= ms_cnt_reg + 1'b1;
    end
  end

  // Phase runs freely so a stat change never restarts the blink cadence.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_reg == BL_W'(BLINK_MS - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------- event glyph hold ----------------
  logic [3:0]        ev_code_in;
  logic              ev_load;
  logic [3:0]        ev_code_reg;
  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              unused_event_bits;

  assign ev_code_in        = i_input_event[15:12];
  assign ev_load           = (ev_code_in >= 4'd1) && (ev_code_in <= 4'd4);
  assign unused_event_bits = ^i_input_event[11:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ev_code_reg  <= '0;
      hold_cnt_reg <= '0;
    end else if (ev_load) begin
      ev_code_reg  <= ev_code_in;
      hold_cnt_reg <= HOLD_W'(FLASH_MS);
    end else if (tick && (hold_cnt_reg != '0)) begin
      hold_cnt_reg <= hold_cnt_reg - 1'b1;
    end
  end

  // ---------------- binary -> BCD conversion FSM ----------------
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t            state_reg, state_next;
  logic [TIME_W-1:0] bin_reg, bin_next;
  logic [4*TD-1:0]   work_reg, work_next;
  logic [BIT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic              sat_reg, sat_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [TIME_W-1:0] pend_val_reg, pend_val_next;
  logic [4*TD-1:0]   bcd_reg, bcd_next;
  logic              busy_reg, busy_next;
  logic [4*TD-1:0]   adj;
  logic              start;
  logic [TIME_W-1:0] start_val;

  genvar gi;
  generate
    for (gi = 0; gi < TD; gi++) begin : g_dabble
      logic [3:0] d;
      assign d = work_reg[4*gi +: 4];
      assign adj[4*gi +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    bin_next        = bin_reg;
    work_next       = work_reg;
    bit_cnt_next    = bit_cnt_reg;
    sat_next        = sat_reg;
    pend_valid_next = pend_valid_reg;
    pend_val_next   = pend_val_reg;
    bcd_next        = bcd_reg;
    busy_next       = (state_reg != ST_IDLE);
    start           = 1'b0;
    start_val       = i_time;

    case (state_reg)
      ST_IDLE: begin
        if (i_time_valid) start = 1'b1;
      end
      ST_SHIFT: begin
        if (i_time_valid) begin
          pend_valid_next = 1'b1;
          pend_val_next   = i_time;
        end
        work_next    = {adj[4*TD-2:0], bin_reg[TIME_W-1]};
        bin_next     = bin_reg << 1;
        bit_cnt_next = bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == BIT_W'(TIME_W - 1)) state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        bcd_next = sat_reg ? ALL_NINES : work_reg;
        // A strobe landing on the commit cycle is newer than the pending slot.
        if (i_time_valid || pend_valid_reg) begin
          start           = 1'b1;
          start_val       = i_time_valid ? i_time : pend_val_reg;
          pend_valid_next = 1'b0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (start) begin
      state_next   = ST_SHIFT;
      bin_next     = start_val;
      work_next    = '0;
      bit_cnt_next = '0;
      sat_next     = (64'(start_val) >= SAT_LIMIT);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg      <= ST_IDLE;
      bin_reg        <= '0;
      work_reg       <= '0;
      bit_cnt_reg    <= '0;
      sat_reg        <= 1'b0;
      pend_valid_reg <= 1'b0;
      pend_val_reg   <= '0;
      bcd_reg        <= '0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bin_reg        <= bin_next;
      work_reg       <= work_next;
      bit_cnt_reg    <= bit_cnt_next;
      sat_reg        <= sat_next;
      pend_valid_reg <= pend_valid_next;
      pend_val_reg   <= pend_val_next;
      bcd_reg        <= bcd_next;
      busy_reg       <= busy_next;
    end
  end

  // ---------------- segment assembly ----------------
  logic [6:0]              stat_glyph;
  logic [6:0]              ev_glyph;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic [7*NUM_DIGITS-1:0] seg_reg;

  always_comb begin
    stat_glyph = G_E;
    case (i_stat)
      3'd0:    stat_glyph = G_DASH;
      3'd1:    stat_glyph = G_P;
      3'd2:    stat_glyph = blink_phase_reg ? G_BLANK : G_P;
      3'd3:    stat_glyph = G_R;
      3'd4:    stat_glyph = blink_phase_reg ? G_BLANK : G_R;
      default: stat_glyph = G_E;
    endcase
  end

  always_comb begin
    ev_glyph = G_BLANK;
    if (hold_cnt_reg != '0) begin
      case (ev_code_reg)
        4'd1:    ev_glyph = G_P;
        4'd2:    ev_glyph = G_H;
        4'd3:    ev_glyph = G_S;
        4'd4:    ev_glyph = G_R;
        default: ev_glyph = G_BLANK;
      endcase
    end
  end

  assign seg_next[7*(NUM_DIGITS-1) +: 7] = stat_glyph;
  assign seg_next[7*TD +: 7]             = ev_glyph;

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [TD:0] zero_from;
  assign zero_from[TD] = 1'b1;
  generate
    for (gi = 0; gi < TD; gi++) begin : g_time_lz
      assign zero_from[gi] = (bcd_reg[4*gi +: 4] == 4'd0) && zero_from[gi+1];
      if (gi == 0) begin : g_units
        assign seg_next[6:0] = digit_glyph(bcd_reg[3:0]);
      end else begin : g_upper
        assign seg_next[7*gi +: 7] = zero_from[gi] ? G_BLANK : digit_glyph(bcd_reg[4*gi +: 4]);
      end
    end
  endgenerate
`else
  generate
    for (gi = 0; gi < TD; gi++) begin : g_time
      assign seg_next[7*gi +: 7] = digit_glyph(bcd_reg[4*gi +: 4]);
    end
  endgenerate
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seg_reg <= '1;
    end else begin
      seg_reg <= seg_next;
    end
  end

  assign o_seg  = seg_reg;
  assign o_busy = busy_reg;

endmodule

// File: tb/tb_seg_status_display.sv
// Randomised self-checking bench for seg_status_display against a spec-level reference model.
module tb_seg_status_display;

  localparam int ND    = 8;
  localparam int TW    = 20;
  localparam int TD    = ND - 2;
  localparam int FLASH = 3;
  localparam int BLINK = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [TW-1:0]     tval;
  logic              tvalid;
  logic [2:0]        stat;
  logic [15:0]       ev;
  logic [7*ND-1:0]   seg;
  logic              busy;

  int     vectors = 0;
  int     miscompares = 0;
  longint shown_val = 0;
  logic [6:0] glyph_tab [10];

  always #5 clk = ~clk;

  seg_status_display #(
    .NUM_DIGITS(ND), .TIME_W(TW), .CLK_HZ(1000), .BLINK_MS(BLINK), .FLASH_MS(FLASH)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_time(tval), .i_time_valid(tvalid),
    .i_stat(stat), .i_input_event(ev), .o_seg(seg), .o_busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected time digits from the decimal value itself.
  function automatic logic [7*TD-1:0] exp_time(input longint v);
    logic [7*TD-1:0] r;
    longint p;
    int d;
    p = 1;
    for (int k = 0; k < TD; k++) begin
      if (v >= 1000000) d = 9;
      else d = int'((v / p) % 10);
      r[7*k +: 7] = glyph_tab[d];
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (k > 0 && v < p) r[7*k +: 7] = 7'h7F;
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] stat_steady(input int s);
    case (s)
      0: return 7'h3F;
      1, 2: return 7'h0C;
      3, 4: return 7'h2F;
      default: return 7'h06;
    endcase
  endfunction

  function automatic logic [6:0] ev_glyph(input logic [3:0] c);
    case (c)
      4'd1: return 7'h0C;
      4'd2: return 7'h09;
      4'd3: return 7'h12;
      4'd4: return 7'h2F;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; tvalid = 1'b0; tval = '0; stat = 3'd0; ev = '0;
    step(); step();
    vectors++;
    if (seg !== '1) begin miscompares++; $display("FAIL reset_seg got %h want all ones", seg); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    #2 rst = 1'b0;
    step();
    vectors++;
    if (seg[7*ND-1 -: 7] !== 7'h3F) begin miscompares++; $display("FAIL post_reset_d7 got %h want 3f", seg[7*ND-1 -: 7]); end
    vectors++;
    if (seg[7*TD +: 7] !== 7'h7F) begin miscompares++; $display("FAIL post_reset_d6 got %h want 7f", seg[7*TD +: 7]); end
    vectors++;
    if (seg[7*TD-1:0] !== exp_time(0)) begin miscompares++; $display("FAIL post_reset_time got %h want %h", seg[7*TD-1:0], exp_time(0)); end
    shown_val = 0;
  endtask

  task automatic run_conversion(input longint v);
    tval = TW'(v); tvalid = 1'b1;
    step();
    tvalid = 1'b0; tval = TW'($urandom);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_at_capture v=%0d got %b want 0", v, busy); end
    for (int k = 1; k <= TW + 1; k++) begin
      step();
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_during v=%0d k=%0d got %b want 1", v, k, busy); end
      vectors++;
      if (seg[7*TD-1:0] !== exp_time(shown_val)) begin
        miscompares++; $display("FAIL time_hold v=%0d k=%0d got %h want %h", v, k, seg[7*TD-1:0], exp_time(shown_val));
      end
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL busy_done v=%0d got %b want 0", v, busy); end
    vectors++;
    if (seg[7*TD-1:0] !== exp_time(v)) begin miscompares++; $display("FAIL time_value v=%0d got %h want %h", v, seg[7*TD-1:0], exp_time(v)); end
    shown_val = v;
  endtask

  task automatic test_convert();
    longint directed [6] = '{123456, 42, 1000000, 0, 999999, 1048575};
    foreach (directed[i]) run_conversion(directed[i]);
    for (int i = 0; i < 6; i++) run_conversion(longint'($urandom_range(0, (1 << TW) - 1)));
  endtask

  task automatic test_back_to_back();
    longint old_val;
    longint want_val;
    logic   want_busy;
    old_val = shown_val;
    tval = TW'(5); tvalid = 1'b1;
    step();
    for (int n = 1; n <= 50; n++) begin
      tvalid = (n == 1 || n == 5);
      tval   = (n == 1) ? TW'(6) : TW'(7);
      step();
      want_busy = (n <= 42);
      vectors++;
      if (busy !== want_busy) begin miscompares++; $display("FAIL b2b_busy n=%0d got %b want %b", n, busy, want_busy); end
      if (n == 21 || n == 22 || n == 42 || n == 43 || n == 50) begin
        want_val = (n < 22) ? old_val : (n < 43) ? 5 : 7;
        vectors++;
        if (seg[7*TD-1:0] !== exp_time(want_val)) begin
          miscompares++; $display("FAIL b2b_time n=%0d got %h want %h", n, seg[7*TD-1:0], exp_time(want_val));
        end
      end
    end
    tvalid = 1'b0;
    shown_val = 7;
  endtask

  task automatic test_blink();
    logic [6:0] d7;
    logic [6:0] prev;
    logic [6:0] on_g;
    int run;
    int trans;
    int s;
    for (int pass = 0; pass < 2; pass++) begin
      s = (pass == 0) ? 2 : 4;
      on_g = stat_steady(s);
      stat = 3'(s);
      step();
      prev = 7'h55; run = 0; trans = 0;
      for (int c = 0; c < 40; c++) begin
        step();
        d7 = seg[7*ND-1 -: 7];
        vectors++;
        if (d7 !== on_g && d7 !== 7'h7F) begin miscompares++; $display("FAIL blink_glyph stat=%0d got %h want %h/7f", s, d7, on_g); end
        if (d7 === prev) begin
          run++;
        end else begin
          if (trans > 1) begin
            vectors++;
            if (run !== BLINK) begin miscompares++; $display("FAIL blink_period stat=%0d got %0d want %0d", s, run, BLINK); end
          end
          trans++;
          run = 1;
        end
        prev = d7;
      end
      vectors++;
      if (trans < 6) begin miscompares++; $display("FAIL blink_toggles stat=%0d got %0d want >=6", s, trans); end
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 4) continue;
      stat = 3'(i);
      for (int c = 0; c < 9; c++) begin
        step();
        vectors++;
        if (seg[7*ND-1 -: 7] !== stat_steady(i)) begin
          miscompares++; $display("FAIL stat_glyph stat=%0d got %h want %h", i, seg[7*ND-1 -: 7], stat_steady(i));
        end
      end
    end
    stat = 3'd0;
  endtask

  task automatic test_event();
    int last_load;
    logic [3:0] last_code;
    logic [3:0] code;
    logic [6:0] want;
    last_load = -100; last_code = 4'd0;
    for (int c = 0; c < 80; c++) begin
      if (c < 12) code = (c == 0) ? 4'd4 : (c == 2) ? 4'd2 : (c == 7) ? 4'd9 : 4'd0;
      else code = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      ev = {code, 12'($urandom)};
      step();
      want = (c - last_load >= 1 && c - last_load <= FLASH) ? ev_glyph(last_code) : 7'h7F;
      vectors++;
      if (seg[7*TD +: 7] !== want) begin miscompares++; $display("FAIL event_glyph c=%0d got %h want %h", c, seg[7*TD +: 7], want); end
      if (code >= 4'd1 && code <= 4'd4) begin last_load = c; last_code = code; end
    end
    ev = '0;
    for (int c = 0; c < FLASH + 1; c++) step();
  endtask

  task automatic test_reset_mid();
    tval = TW'(777777); tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    for (int k = 1; k <= 10; k++) step();
    tval = TW'(3333); tvalid = 1'b1;
    step();
    tvalid = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    vectors++;
    if (seg !== '1) begin miscompares++; $display("FAIL midrst_seg got %h want all ones", seg); end
    step();
    vectors++;
    if (seg !== '1) begin miscompares++; $display("FAIL midrst_hold_seg got %h want all ones", seg); end
    #2 rst = 1'b0;
    step();
    vectors++;
    if (seg[7*TD-1:0] !== exp_time(0)) begin miscompares++; $display("FAIL midrst_time got %h want %h", seg[7*TD-1:0], exp_time(0)); end
    for (int c = 0; c < 30; c++) begin
      step();
      vectors++;
      if (busy !== 1'b0 || seg[7*TD-1:0] !== exp_time(0)) begin
        miscompares++; $display("FAIL midrst_idle c=%0d got busy=%b time=%h want busy=0 time=%h", c, busy, seg[7*TD-1:0], exp_time(0));
      end
    end
    shown_val = 0;
  endtask

  initial begin
    glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    test_reset();
    test_convert();
    test_back_to_back();
    test_blink();
    test_event();
    test_reset_mid();
    run_conversion(longint'($urandom_range(0, 999999)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
